// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: controller states, instruction
// field encodings and the ALU operation set.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  // Unrecognised funct codes fall back to add.
  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  funct_to_alu = ALU_SUB;
      FN_AND:  funct_to_alu = ALU_AND;
      FN_OR:   funct_to_alu = ALU_OR;
      FN_XOR:  funct_to_alu = ALU_XOR;
      FN_SLL:  funct_to_alu = ALU_SLL;
      FN_SRL:  funct_to_alu = ALU_SRL;
      FN_MUL:  funct_to_alu = ALU_MUL;
      default: funct_to_alu = ALU_ADD;
    endcase
  endfunction

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW: opcode_legal = 1'b1;
      default:                                               opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port; register 0 ignores writes and always reads zero.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs_r [NREGS];

  // Register array: cleared on reset, single write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs_r[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs_r[raddr_b];

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle MIPS-subset core: six-state controller, combinational ALU,
// combinational instruction fetch and a request/ready data memory port.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          DMEM_ADDR_W = 6,
  parameter int          IMEM_ADDR_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [31:0]            dmem_wdata,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_ready,
  output logic                   retire,
  output logic                   halted
);

  state_t state_r, next_state_s;
  logic [31:0] pc_r, ir_r, a_r, b_r, imm_r, wb_data_r;
  logic        dmem_req_r, dmem_we_r, retire_r, halted_r, retire_s;
  logic [DMEM_ADDR_W-1:0] dmem_addr_r;
  logic [31:0] dmem_wdata_r;

  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
  logic [31:0] rdata_a_s, rdata_b_s, alu_b_s, alu_result_s;
  logic [31:0] branch_target_s, jump_target_s, rf_wdata_s;
  logic [4:0]  rf_waddr_s;
  logic        rf_we_s;
  alu_op_t     alu_op_s;

  assign opcode_s = ir_r[31:26];
  assign rs_s     = ir_r[25:21];
  assign rt_s     = ir_r[20:16];
  assign rd_s     = ir_r[15:11];
  assign shamt_s  = ir_r[10:6];
  assign funct_s  = ir_r[5:0];

  assign branch_target_s = pc_r + {imm_r[29:0], 2'b00};
  assign jump_target_s   = {pc_r[31:28], ir_r[25:0], 2'b00};

  cpu_regfile u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (rf_we_s && enable),
    .waddr   (rf_waddr_s),
    .wdata   (rf_wdata_s),
    .raddr_a (rs_s),
    .raddr_b (rt_s),
    .rdata_a (rdata_a_s),
    .rdata_b (rdata_b_s)
  );

  // ALU: R-type uses B and funct, everything else adds the immediate to A.
  always_comb begin
    alu_op_s     = ALU_ADD;
    alu_b_s      = imm_r;
    alu_result_s = '0;
    if (opcode_s == OP_RTYPE) begin
      alu_op_s = funct_to_alu(funct_s);
      alu_b_s  = b_r;
    end else begin
      alu_op_s = ALU_ADD;
      alu_b_s  = imm_r;
    end
    case (alu_op_s)
      ALU_ADD: alu_result_s = a_r + alu_b_s;
      ALU_SUB: alu_result_s = a_r - alu_b_s;
      ALU_AND: alu_result_s = a_r & alu_b_s;
      ALU_OR:  alu_result_s = a_r | alu_b_s;
      ALU_XOR: alu_result_s = a_r ^ alu_b_s;
      ALU_SLL: alu_result_s = b_r << shamt_s;
      ALU_SRL: alu_result_s = b_r >> shamt_s;
      ALU_MUL: alu_result_s = a_r * alu_b_s;
      default: alu_result_s = a_r + alu_b_s;
    endcase
  end

  // Next state, retire strobe and register-file write selection.
  always_comb begin
    next_state_s = state_r;
    retire_s     = 1'b0;
    rf_we_s      = 1'b0;
    rf_waddr_s   = rt_s;
    rf_wdata_s   = wb_data_r;
    case (state_r)
      FETCH: next_state_s = DECODE;
      DECODE: begin
        if (opcode_legal(opcode_s)) next_state_s = EXEC;
        else                        next_state_s = HALT;
      end
      EXEC: begin
        case (opcode_s)
          OP_LW, OP_SW: next_state_s = MEM;
          OP_ADDI:      next_state_s = WB;
          OP_RTYPE: begin
            if (funct_s == FN_JR) begin
              next_state_s = FETCH;
              retire_s     = 1'b1;
            end else begin
              next_state_s = WB;
            end
          end
          OP_JAL: begin
            next_state_s = FETCH;
            retire_s     = 1'b1;
            rf_we_s      = 1'b1;
            rf_waddr_s   = 5'd31;
            rf_wdata_s   = pc_r;
          end
          default: begin
            next_state_s = FETCH;
            retire_s     = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (dmem_ready) begin
          if (dmem_we_r) begin
            next_state_s = FETCH;
            retire_s     = 1'b1;
          end else begin
            next_state_s = WB;
          end
        end else begin
          next_state_s = MEM;
        end
      end
      WB: begin
        next_state_s = FETCH;
        retire_s     = 1'b1;
        rf_we_s      = 1'b1;
        rf_waddr_s   = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
      end
      HALT:    next_state_s = HALT;
      default: next_state_s = FETCH;
    endcase
  end

  // Datapath and output registers; enable low freezes everything but retire.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      ir_r         <= '0;
      a_r          <= '0;
      b_r          <= '0;
      imm_r        <= '0;
      wb_data_r    <= '0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= '0;
      dmem_wdata_r <= '0;
      retire_r     <= 1'b0;
      halted_r     <= 1'b0;
    end else if (enable) begin
      state_r  <= next_state_s;
      retire_r <= retire_s;
      case (state_r)
        FETCH: begin
          ir_r <= imem_rdata;
          pc_r <= pc_r + 32'd4;
        end
        DECODE: begin
          a_r   <= rdata_a_s;
          b_r   <= rdata_b_s;
          imm_r <= {{16{ir_r[15]}}, ir_r[15:0]};
          if (!opcode_legal(opcode_s)) halted_r <= 1'b1;
        end
        EXEC: begin
          wb_data_r <= alu_result_s;
          case (opcode_s)
            OP_LW, OP_SW: begin
              dmem_req_r   <= 1'b1;
              dmem_we_r    <= (opcode_s == OP_SW);
              dmem_addr_r  <= alu_result_s[DMEM_ADDR_W+1:2];
              dmem_wdata_r <= b_r;
            end
            OP_BEQ:       if (a_r == b_r) pc_r <= branch_target_s;
            OP_J, OP_JAL: pc_r <= jump_target_s;
            OP_RTYPE:     if (funct_s == FN_JR) pc_r <= a_r;
            default:      ;
          endcase
        end
        MEM: begin
          if (dmem_ready) begin
            dmem_req_r <= 1'b0;
            if (!dmem_we_r) wb_data_r <= dmem_rdata;
          end
        end
        default: ;
      endcase
    end else begin
      retire_r <= 1'b0;
    end
  end

  assign imem_addr  = pc_r[IMEM_ADDR_W-1:0];
  assign dmem_req   = dmem_req_r;
  assign dmem_we    = dmem_we_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_wdata = dmem_wdata_r;
  assign retire     = retire_r;
  assign halted     = halted_r;

endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 Parameter RESET_PC, default 0: byte address loaded into PC on reset.
REQ-002 Parameter DMEM_ADDR_W, default 6: word-address width of dmem_addr.
REQ-003 Parameter IMEM_ADDR_W, default 8: byte-address width of imem_addr.
REQ-004 clock  in  1  sole clock; all state updates on posedge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  when 0, all state holds and no strobes assert.
REQ-007 imem_addr  out  IMEM_ADDR_W  PC low bits; instruction memory read is combinational.
REQ-008 imem_rdata  in  32  instruction word at imem_addr.
REQ-009 dmem_req  out  1  data access request; held until accepted.
REQ-010 dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
REQ-011 dmem_addr  out  DMEM_ADDR_W  word address, equal to ALU result bits [DMEM_ADDR_W+1:2].
REQ-012 dmem_wdata  out  32  store data (rt).
REQ-013 dmem_rdata  in  32  load data; sampled in the cycle dmem_ready=1.
REQ-014 dmem_ready  in  1  accept, and for loads also data valid, in the same cycle.
REQ-015 retire  out  1  one-cycle pulse per completed instruction.
REQ-016 halted  out  1  high after an illegal opcode; sticky until reset.

Function
REQ-017 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-018 FETCH: latch IR <= imem_rdata, PC <= PC+4 -> DECODE.
REQ-019 DECODE: latch A <= reg[rs], B <= reg[rt] and the sign-extended immediate -> EXEC; an illegal opcode goes to HALT.
REQ-020 Supported instructions: R-type add, sub, and, or, xor, sll, srl, mul, jr; I-type addi, lw, sw, beq; J-type j, jal. An unknown funct code SHALL execute as add.
REQ-021 sll/srl SHALL shift rt by shamt (IR[10:6]); mul SHALL write the low 32 bits of the product; all arithmetic wraps modulo 2^32.
REQ-022 EXEC, R-type/addi: compute result -> WB.
REQ-023 EXEC, lw/sw: address = A + imm -> MEM.
REQ-024 EXEC, beq: if A==B then PC <= PC + (imm<<2) -> FETCH, retire.
REQ-025 EXEC, j: PC <= {PC[31:28], IR[25:0], 2'b00} -> FETCH, retire.
REQ-026 EXEC, jal: as j, plus reg[31] <= PC (the already-incremented PC), retire.
REQ-027 EXEC, jr: PC <= A -> FETCH, retire.
REQ-028 MEM: assert dmem_req until dmem_ready=1. A store then goes -> FETCH with retire; a load latches dmem_rdata -> WB.
REQ-029 WB: write rd (R-type) or rt (addi/lw) -> FETCH, retire.
REQ-030 Writes to reg[0] SHALL be discarded; reg[0] SHALL always read 0.
REQ-031 Latency with zero wait: branch/jump 3 cycles; ALU op 4 cycles; sw 4 cycles; lw 5 cycles. Each dmem_ready=0 cycle adds one cycle.
REQ-032 enable=0 while in MEM SHALL hold dmem_req and all outputs unchanged.
REQ-033 HALT: no PC change, no strobes, halted=1.
REQ-034 PC arithmetic SHALL wrap at 2^32; imem_addr is truncated.

Reset
REQ-035 reset=1 at posedge clock: PC=RESET_PC, state=FETCH, registers and IR=0, dmem_req=0, dmem_we=0, retire=0, halted=0.
REQ-036 Reset SHALL override enable and any pending MEM handshake; an abandoned request is dropped without retire.

Structure
REQ-037 A shared package cpu_pkg SHALL hold the opcode/funct constants, the state enum and the ALU-op encoding.
REQ-038 One sub-module, cpu_regfile: 32x32, two combinational read ports, one synchronous write port, reg0 hardwired to 0.
REQ-039 The ALU SHALL be combinational inside cpu_multicycle.

Verification
REQ-040 Aspect-ratio program, a0=161, a1=90, a2=3, a3=4, ending with jal to a self-loop -> mem word 4 (byte 16) = 0.
REQ-041 Same program with a0=160 -> mem word 4 = 2; with a0=120 -> mem word 4 = 1.
REQ-042 jal at PC 36 -> reg[31]=40; jr $ra -> next fetch at 40; each retires after 3 cycles.
REQ-043 lw with dmem_ready held low 3 cycles -> dmem_req steady for 4 cycles, retire 8 cycles after FETCH, correct rt value.
REQ-044 addi $0,$0,5 then add $t0,$0,$0 -> t0=0; opcode 6'b111111 -> halted=1, PC frozen; reset -> PC=RESET_PC, halted=0.
REQ-045 Reset asserted during a MEM wait -> next cycle dmem_req=0, state FETCH, no write to memory.
